// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a length-prefixed 8N1 UART word stream and writes little-endian 32-bit words to instruction memory
// Ports: clk, rst_n (async active-low); load_req rising edge starts a load; uart_rx serial input (idle high);
//   imem_we/imem_addr/imem_wdata one-cycle memory write; busy/done/err load status; cpu_rst_n holds the CPU
//   in reset until a successful load; word_cnt counts words written in the current/last load.
// Optional: define UART_BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module uart_boot_loader #(
  parameter int CLK_FREQ   = 23_000_000,
  parameter int BAUD       = 115_200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req,
  input  logic                  uart_rx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cpu_rst_n,
  output logic [15:0]           word_cnt
);
  localparam int CPB = (CLK_FREQ / BAUD < 4) ? 4 : CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA,
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } st_e;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam st_e AFTER = CHK;
  logic [7:0] chk_q, chk_d;
`else
  localparam st_e AFTER = DONE;
`endif
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  rx_e rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic byte_valid, frame_err;
  logic req_q, req_rise;
  st_e st_q, st_d;
  logic [15:0] len_q, len_d, len_new, word_cnt_q, word_cnt_d;
  logic [23:0] word_q, word_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic we_q, we_d, cpu_q, cpu_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  assign req_rise = load_req & ~req_q;
  assign len_new = {sh_q, len_q[7:0]};
  assign busy = !(st_q inside {IDLE, DONE, ERR});
  assign done = st_q == DONE;
  assign err = st_q == ERR;
  assign cpu_rst_n = cpu_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign word_cnt = word_cnt_q;
  // The start bit is re-checked half a bit after the falling edge, which also places every later sample mid-bit.
  always_comb begin
    rx_st_d = rx_st_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (rx_st_q)
      RX_START: if (cnt_q == CW'(CPB / 2 - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        sh_d = {rx_s2_q, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        rx_st_d = bit_q == 3'd7 ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (cnt_q == CW'(CPB - 1)) begin
        rx_st_d = RX_IDLE;
        byte_valid = rx_s2_q;
        frame_err = !rx_s2_q;
      end
      default: begin
        cnt_d = '0;
        rx_st_d = rx_prev_q && !rx_s2_q ? RX_START : RX_IDLE;
      end
    endcase
  end
  always_comb begin
    st_d = st_q;
    len_d = len_q;
    word_d = word_q;
    bcnt_d = bcnt_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    word_cnt_d = word_cnt_q + {15'd0, we_q};
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    chk_d = chk_q;
`endif
    case (st_q)
      LEN_LO: if (byte_valid) begin
        len_d[7:0] = sh_q;
        st_d = LEN_HI;
      end
      LEN_HI: if (byte_valid) begin
        len_d = len_new;
        bcnt_d = '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        chk_d = '0;
`endif
        st_d = len_new == 16'd0 ? AFTER : {17'd0, len_new} > CAP ? ERR : DATA;
      end
      // word_cnt lags the write strobe by a cycle, so the exit test sees the final count one cycle after the last write.
      DATA: if (word_cnt_q == len_q) st_d = AFTER;
      else if (byte_valid) begin
        word_d = {sh_q, word_q[23:8]};
        bcnt_d = bcnt_q + 2'd1;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        chk_d = chk_q ^ sh_q;
`endif
        we_d = bcnt_q == 2'd3;
        wdata_d = we_d ? {sh_q, word_q} : wdata_q;
        addr_d = we_d ? word_cnt_q[ADDR_WIDTH-1:0] : addr_q;
      end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      CHK: if (byte_valid) st_d = sh_q == chk_q ? DONE : ERR;
`endif
      default: if (req_rise) begin
        st_d = LEN_LO;
        word_cnt_d = '0;
        addr_d = '0;
      end
    endcase
    if (frame_err && busy) st_d = ERR;
    // CPU leaves reset one cycle after DONE is entered and drops in the same cycle DONE is left.
    cpu_d = st_q == DONE && st_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      req_q <= 1'b0;
      st_q <= IDLE;
      len_q <= '0;
      word_q <= '0;
      bcnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      word_cnt_q <= '0;
      cpu_q <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q <= rx_st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      req_q <= load_req;
      st_q <= st_d;
      len_q <= len_d;
      word_q <= word_d;
      bcnt_q <= bcnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      word_cnt_q <= word_cnt_d;
      cpu_q <= cpu_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized loads checked against a queue-based reference of expected writes and status
module tb_uart_boot_loader;
  localparam int CPB = 10;
  logic clk = 1'b0, rst_n = 1'b0, load_req = 1'b0, uart_rx = 1'b1;
  logic imem_we, busy, done, err, cpu_rst_n;
  logic [3:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] word_cnt;
  int passed = 0, total = 0;
  typedef struct packed {logic [3:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  logic [7:0] data_q[$];
  uart_boot_loader #(.CLK_FREQ(1_000_000), .BAUD(100_000), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .uart_rx(uart_rx),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_rst_n(cpu_rst_n), .word_cnt(word_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (imem_we) begin
      if (exp_q.size() == 0) chk("spurious_write", 32'd1, 32'd0);
      else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(w.a));
        chk("write_data", imem_wdata, w.d);
      end
    end
    chk("status_legal", 32'(((32'(busy) + 32'(done) + 32'(err)) <= 1) && (!cpu_rst_n || done)), 32'd1);
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
  endtask
  task automatic glitch();
    @(posedge clk);
    uart_rx = 1'b0;
    @(posedge clk);
    uart_rx = 1'b1;
    repeat (12) @(posedge clk);
  endtask
  task automatic gap(input bit poke);
    if (poke) begin
      load_req = 1'b1;
      repeat (2) @(posedge clk);
      load_req = 1'b0;
    end
    repeat ($urandom_range(0, 12)) @(posedge clk);
  endtask
  task automatic start_load();
    glitch();
    @(posedge clk);
    load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("start_word_cnt", 32'(word_cnt), 32'd0);
    chk("start_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    load_req = 1'b0;
    glitch();
  endtask
  task automatic fill(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
  endtask
  // lit: the caller already queued literal expected writes and supplied data_q.
  task automatic do_load(input int len, input int bad_idx, input bit bad_chk, input bit lit);
    int nw;
    bit fail;
    logic [7:0] x;
    if (!lit) fill(len <= 16 ? 4 * len : 0);
    nw = len > 16 ? 0 : bad_idx >= 0 ? bad_idx / 4 : len;
    fail = len > 16 || bad_idx >= 0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    fail = fail || bad_chk;
`endif
    x = 8'd0;
    for (int i = 0; i < data_q.size(); i++) x = x ^ data_q[i];
    if (!lit)
      for (int w = 0; w < nw; w++)
        exp_q.push_back({4'(w), data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]});
    start_load();
    send_byte(8'(len), 1'b1);
    gap(1'b0);
    send_byte(8'(len >> 8), 1'b1);
    if (len <= 16) begin
      for (int i = 0; i < 4 * len; i++) begin
        if (i > 0) gap($urandom_range(0, 3) == 0);
        send_byte(data_q[i], i != bad_idx);
        if (i == bad_idx) begin
          repeat (CPB) @(posedge clk);
          break;
        end
      end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      if (bad_idx < 0) begin
        gap(1'b0);
        send_byte(bad_chk ? x ^ 8'h01 : x, 1'b1);
      end
`endif
    end
    repeat (2) @(negedge clk);
    chk("end_done", 32'(done), 32'(!fail));
    chk("end_err", 32'(err), 32'(fail));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_cpu_rst_n", 32'(cpu_rst_n), 32'(!fail));
    chk("end_word_cnt", 32'(word_cnt), 32'(nw));
    chk("writes_missing", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask
  task automatic load_fixed();
    data_q = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
    exp_q.push_back({4'd0, 32'h00A0_0513});
    exp_q.push_back({4'd1, 32'h00B5_05B3});
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int len, bad;
    #12;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    load_fixed();
    do_load(2, -1, 1'b0, 1'b1);
    chk("fixed_word_cnt", 32'(word_cnt), 32'd2);
    do_load(0, -1, 1'b0, 1'b0);
    do_load(17, -1, 1'b0, 1'b0);
    do_load(2, 2, 1'b0, 1'b0);
    do_load(1, -1, 1'b0, 1'b0);
    fill(12);
    exp_q.push_back({4'd0, data_q[3], data_q[2], data_q[1], data_q[0]});
    start_load();
    send_byte(8'd3, 1'b1);
    send_byte(8'd0, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(data_q[i], 1'b1);
    repeat ($urandom_range(1, 20)) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_writes", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_load(2, -1, 1'b0, 1'b0);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    load_fixed();
    do_load(2, -1, 1'b1, 1'b1);
`endif
    do_load(16, -1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(0, 7) == 0 ? 17 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
      bad = (len > 0 && len <= 16 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4 * len - 1)) : -1;
      do_load(len, bad, $urandom_range(0, 3) == 0, 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
